// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - Pong game-state engine; PONG_SPEEDUP_EN enables rally-based ball speed-up
module pong_engine #(
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int BALL_SIZE   = 10,
  parameter int PAD_W       = 12,
  parameter int PAD_H       = 60,
  parameter int PAD1_X      = 13,
  parameter int PAD2_X      = 615,
  parameter int PAD_STEP    = 30,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic        tick,
  input  logic        start,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [11:0] pad1_y,
  output logic [11:0] pad2_y,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [1:0]  state,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SERVE    = 2'd1,
    ST_PLAY     = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_t;

  localparam logic [11:0] BALL_X0 = 12'((FRAME_W - BALL_SIZE) / 2);
  localparam logic [11:0] BALL_Y0 = 12'((FRAME_H - BALL_SIZE) / 2);
  localparam logic [11:0] PAD_Y0  = 12'((FRAME_H - PAD_H) / 2);
  localparam logic [11:0] PAD_MAX = 12'(FRAME_H - PAD_H);
  localparam logic [11:0] STEP    = 12'(PAD_STEP);
  localparam logic [11:0] BALL    = 12'(BALL_SIZE);
  localparam logic [11:0] HALF    = 12'(BALL_SIZE / 2);
  localparam logic [11:0] FW      = 12'(FRAME_W);
  localparam logic [11:0] FH      = 12'(FRAME_H);
  localparam logic [11:0] L_FACE  = 12'(PAD1_X + PAD_W);
  localparam logic [11:0] R_FACE  = 12'(PAD2_X);
  localparam logic [11:0] PH      = 12'(PAD_H);
  localparam logic [11:0] ZSTEP   = 12'(PAD_H / 5);
  localparam logic [11:0] DELAY   = 12'(SERVE_DELAY);
  localparam logic [3:0]  WIN     = 4'(WIN_SCORE);

  // Saturating paddle step; simultaneous up and down cancel out.
  function automatic logic [11:0] pad_move(input logic [11:0] p, input logic up, input logic dn);
    logic [11:0] r;
    r = p;
    if (up && !dn) r = (p >= STEP) ? p - STEP : 12'd0;
    else if (dn && !up) r = (p + STEP > PAD_MAX) ? PAD_MAX : p + STEP;
    return r;
  endfunction

  // Which fifth of the paddle the ball centre struck, clamped to the paddle extent.
  function automatic logic [2:0] zone_of(input logic [11:0] by, input logic [11:0] py);
    logic [11:0] d;
    logic [2:0]  z;
    if (by + HALF < py) d = 12'd0;
    else d = by + HALF - py;
    if (d > PH - 12'd1) d = PH - 12'd1;
    if (d < ZSTEP) z = 3'd0;
    else if (d < ZSTEP * 12'd2) z = 3'd1;
    else if (d < ZSTEP * 12'd3) z = 3'd2;
    else if (d < ZSTEP * 12'd4) z = 3'd3;
    else z = 3'd4;
    return z;
  endfunction

  function automatic logic [11:0] zone_vx(input logic [2:0] z);
    logic [11:0] v;
    case (z)
      3'd0, 3'd4: v = 12'd2;
      3'd1, 3'd3: v = 12'd3;
      default:    v = 12'd4;
    endcase
    return v;
  endfunction

  function automatic logic [11:0] zone_vy(input logic [2:0] z);
    logic [11:0] v;
    case (z)
      3'd0, 3'd4: v = 12'd2;
      3'd1, 3'd3: v = 12'd1;
      default:    v = 12'd0;
    endcase
    return v;
  endfunction

  state_t      state_q, state_d;
  logic [11:0] vx, vy, serve_cnt;
  logic        dir_x, dir_y, serve_dir;   // dir_x 1 = right, dir_y 1 = down, serve_dir 1 = right

  logic [11:0] ball_x_d, ball_y_d, pad1_y_d, pad2_y_d, vx_d, vy_d, serve_cnt_d;
  logic [3:0]  score1_d, score2_d;
  logic [1:0]  winner_d;
  logic        dir_x_d, dir_y_d, serve_dir_d;

  logic        overlap1, overlap2, hit1, hit2, miss1, miss2;
  logic [2:0]  zone;
  logic [11:0] bonus, vx_sum, hit_vx, y_move;
  logic        y_dir;
  logic [3:0]  score1_inc, score2_inc;

  assign state = state_q;

  // Collision predicates all look at pre-move ball and pre-update paddle positions.
  assign overlap1 = (ball_y + BALL > pad1_y) && (ball_y < pad1_y + PH);
  assign overlap2 = (ball_y + BALL > pad2_y) && (ball_y < pad2_y + PH);
  assign hit1  = !dir_x && (ball_x >= L_FACE) && (ball_x - vx < L_FACE) && overlap1;
  assign hit2  = dir_x && (ball_x + BALL <= R_FACE) && (ball_x + BALL + vx > R_FACE) && overlap2;
  assign miss1 = !dir_x && !hit1 && (ball_x < vx);
  assign miss2 = dir_x && !hit2 && (ball_x + BALL + vx > FW);
  assign zone  = zone_of(ball_y, hit2 ? pad2_y : pad1_y);
  assign vx_sum = zone_vx(zone) + bonus;
  assign hit_vx = (vx_sum > 12'd7) ? 12'd7 : vx_sum;
  assign score1_inc = score1 + 4'd1;
  assign score2_inc = score2 + 4'd1;

`ifdef PONG_SPEEDUP_EN
  logic [3:0] rally, rally_d, rally_inc;
  assign rally_inc = (rally == 4'hF) ? rally : rally + 4'd1;
  assign bonus     = {10'd0, rally_inc[3:2]};

  // Rally length: counts paddle hits, cleared whenever a point is scored.
  always_comb begin
    rally_d = rally;
    if (state_q == ST_PLAY && tick) begin
      if (hit1 || hit2) rally_d = rally_inc;
      else if (miss1 || miss2) rally_d = 4'd0;
    end
  end

  // Rally counter register.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) rally <= 4'd0;
    else rally <= rally_d;
  end
`else
  assign bonus = 12'd0;
`endif

  // Vertical move with top/bottom wall reflection.
  always_comb begin
    y_move = ball_y;
    y_dir  = dir_y;
    if (!dir_y) begin
      if (ball_y < vy) begin
        y_move = 12'd0;
        y_dir  = 1'b1;
      end else begin
        y_move = ball_y - vy;
      end
    end else begin
      if (ball_y + BALL + vy > FH) begin
        y_move = FH - BALL;
        y_dir  = 1'b0;
      end else begin
        y_move = ball_y + vy;
      end
    end
  end

  // Match state machine, ball physics, scoring and paddle movement.
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x;
    ball_y_d    = ball_y;
    pad1_y_d    = pad1_y;
    pad2_y_d    = pad2_y;
    score1_d    = score1;
    score2_d    = score2;
    winner_d    = winner;
    vx_d        = vx;
    vy_d        = vy;
    dir_x_d     = dir_x;
    dir_y_d     = dir_y;
    serve_dir_d = serve_dir;
    serve_cnt_d = serve_cnt;

    if (state_q == ST_SERVE || state_q == ST_PLAY) begin
      pad1_y_d = pad_move(pad1_y, p1_up, p1_down);
      pad2_y_d = pad_move(pad2_y, p2_up, p2_down);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SERVE;
          serve_dir_d = 1'b0;
          serve_cnt_d = 12'd0;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          serve_cnt_d = serve_cnt + 12'd1;
          if (serve_cnt + 12'd1 >= DELAY) begin
            state_d = ST_PLAY;
            vx_d    = 12'd4;
            vy_d    = 12'd0;
            dir_x_d = serve_dir;
          end
        end
      end
      ST_PLAY: begin
        if (tick) begin
          ball_y_d = y_move;
          dir_y_d  = y_dir;
          if (hit1 || hit2) begin
            ball_x_d = hit1 ? L_FACE : R_FACE - BALL;
            dir_x_d  = hit1;
            vx_d     = hit_vx;
            vy_d     = zone_vy(zone);
            // The centre zone keeps whatever vertical direction the wall logic chose.
            if (zone < 3'd2) dir_y_d = 1'b0;
            else if (zone > 3'd2) dir_y_d = 1'b1;
          end else if (miss1 || miss2) begin
            ball_x_d    = BALL_X0;
            ball_y_d    = BALL_Y0;
            serve_cnt_d = 12'd0;
            // Next serve travels toward whoever just conceded.
            serve_dir_d = miss2;
            if (miss1) score2_d = score2_inc;
            else score1_d = score1_inc;
            if ((miss1 && score2_inc == WIN) || (miss2 && score1_inc == WIN)) begin
              state_d  = ST_GAMEOVER;
              winner_d = miss1 ? 2'd2 : 2'd1;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            ball_x_d = dir_x ? ball_x + vx : ball_x - vx;
          end
        end
      end
      ST_GAMEOVER: begin
        if (start) begin
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          winner_d    = 2'd0;
          pad1_y_d    = PAD_Y0;
          pad2_y_d    = PAD_Y0;
          serve_cnt_d = 12'd0;
          state_d     = ST_SERVE;
        end
      end
      default: ;
    endcase
  end

  // Game-state registers.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      pad1_y    <= PAD_Y0;
      pad2_y    <= PAD_Y0;
      score1    <= 4'd0;
      score2    <= 4'd0;
      winner    <= 2'd0;
      vx        <= 12'd4;
      vy        <= 12'd0;
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      serve_dir <= 1'b0;
      serve_cnt <= 12'd0;
    end else begin
      state_q   <= state_d;
      ball_x    <= ball_x_d;
      ball_y    <= ball_y_d;
      pad1_y    <= pad1_y_d;
      pad2_y    <= pad2_y_d;
      score1    <= score1_d;
      score2    <= score2_d;
      winner    <= winner_d;
      vx        <= vx_d;
      vy        <= vy_d;
      dir_x     <= dir_x_d;
      dir_y     <= dir_y_d;
      serve_dir <= serve_dir_d;
      serve_cnt <= serve_cnt_d;
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// tb/tb_pong_engine.sv - self-checking bench for pong_engine
`timescale 1ns/1ps
module tb_pong_engine;

  logic        CLOCK_25 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        tick = 1'b0, start = 1'b0;
  logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [11:0] ball_x, ball_y, pad1_y, pad2_y;
  logic [3:0]  score1, score2;
  logic [1:0]  state, winner;

  pong_engine dut (
    .CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .tick(tick), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .ball_x(ball_x), .ball_y(ball_y), .pad1_y(pad1_y), .pad2_y(pad2_y),
    .score1(score1), .score2(score2), .state(state), .winner(winner)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: game rules on plain integers, directions as +1/-1.
  int m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_st, m_win;
  int m_vx, m_vy, m_dx, m_dy, m_cnt, m_sdir, m_rally;
  int zvx[5] = '{2, 3, 4, 3, 2};
  int zvy[5] = '{2, 1, 0, 1, 2};
  int zdy[5] = '{-1, -1, 0, 1, 1};

  task automatic model_reset();
    m_bx = 315; m_by = 235; m_p1 = 210; m_p2 = 210;
    m_s1 = 0; m_s2 = 0; m_st = 0; m_win = 0;
    m_vx = 4; m_vy = 0; m_dx = -1; m_dy = -1; m_cnt = 0; m_sdir = -1; m_rally = 0;
  endtask

  function automatic int pad_after(int p, bit up, bit dn);
    if (up && !dn) return (p - 30 < 0) ? 0 : p - 30;
    if (dn && !up) return (p + 30 > 420) ? 420 : p + 30;
    return p;
  endfunction

  function automatic int zone_of(int by, int py);
    int d;
    d = by + 5 - py;
    if (d < 0) d = 0;
    if (d > 59) d = 59;
    return (d * 5) / 60;
  endfunction

  task automatic model_point(int who);
    if (who == 2) begin m_s2++; m_sdir = -1; end
    else begin m_s1++; m_sdir = 1; end
    m_bx = 315; m_by = 235; m_cnt = 0; m_rally = 0;
    if ((who == 2 ? m_s2 : m_s1) == 9) begin m_st = 3; m_win = who; end
    else m_st = 1;
  endtask

  task automatic model_play(int p1o, int p2o);
    int nx, ny, ndy, pad, z;
    bit hit;
    hit = 0; ndy = m_dy; pad = 0; nx = m_bx;
    if (m_dy < 0) begin
      if (m_by < m_vy) begin ny = 0; ndy = 1; end else ny = m_by - m_vy;
    end else begin
      if (m_by + 10 + m_vy > 480) begin ny = 470; ndy = -1; end else ny = m_by + m_vy;
    end
    if (m_dx < 0) begin
      if (m_bx >= 25 && m_bx - m_vx < 25 && m_by + 10 > p1o && m_by < p1o + 60) begin
        hit = 1; nx = 25; pad = p1o;
      end else if (m_bx < m_vx) begin
        model_point(2); return;
      end else nx = m_bx - m_vx;
    end else begin
      if (m_bx + 10 <= 615 && m_bx + 10 + m_vx > 615 && m_by + 10 > p2o && m_by < p2o + 60) begin
        hit = 1; nx = 605; pad = p2o;
      end else if (m_bx + 10 + m_vx > 640) begin
        model_point(1); return;
      end else nx = m_bx + m_vx;
    end
    if (hit) begin
      z = zone_of(m_by, pad);
      m_dx = -m_dx;
      m_rally = (m_rally + 1 > 15) ? 15 : m_rally + 1;
      m_vx = zvx[z];
`ifdef PONG_SPEEDUP_EN
      m_vx = m_vx + ((m_rally / 4 > 3) ? 3 : m_rally / 4);
      if (m_vx > 7) m_vx = 7;
`endif
      m_vy = zvy[z];
      if (zdy[z] != 0) ndy = zdy[z];
    end
    m_bx = nx; m_by = ny; m_dy = ndy;
  endtask

  task automatic model_step(bit tk, bit st, bit a, bit b, bit c, bit d);
    int p1o, p2o;
    p1o = m_p1; p2o = m_p2;
    if (m_st == 1 || m_st == 2) begin
      m_p1 = pad_after(m_p1, a, b);
      m_p2 = pad_after(m_p2, c, d);
    end
    case (m_st)
      0: if (st) begin m_st = 1; m_sdir = -1; m_cnt = 0; end
      1: if (tk) begin
           m_cnt++;
           if (m_cnt == 60) begin m_st = 2; m_vx = 4; m_vy = 0; m_dx = m_sdir; end
         end
      2: if (tk) model_play(p1o, p2o);
      default: if (st) begin
           m_s1 = 0; m_s2 = 0; m_win = 0; m_p1 = 210; m_p2 = 210; m_st = 1; m_cnt = 0;
         end
    endcase
  endtask

  function automatic logic [63:0] mpack();
    return {4'd0, 12'(m_bx), 12'(m_by), 12'(m_p1), 12'(m_p2), 4'(m_s1), 4'(m_s2), 2'(m_st), 2'(m_win)};
  endfunction

  function automatic logic [63:0] dpack();
    return {4'd0, ball_x, ball_y, pad1_y, pad2_y, score1, score2, state, winner};
  endfunction

  // One clock: inputs presented at a falling edge, outputs sampled at the next falling edge.
  task automatic cyc(bit tk, bit st, bit a, bit b, bit c, bit d);
    tick = tk; start = st; p1_up = a; p1_down = b; p2_up = c; p2_down = d;
    model_step(tk, st, a, b, c, d);
    @(negedge CLOCK_25);
    tick = 0; start = 0; p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
  endtask

  task automatic ticks(int n);
    repeat (n) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    RESET_N = 0;
    model_reset();
    @(negedge CLOCK_25);
    RESET_N = 1;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, " ball_x"}, ball_x, 315);
    chk({tag, " ball_y"}, ball_y, 235);
    chk({tag, " pad1_y"}, pad1_y, 210);
    chk({tag, " pad2_y"}, pad2_y, 210);
    chk({tag, " score1"}, score1, 0);
    chk({tag, " score2"}, score2, 0);
    chk({tag, " state"}, state, 0);
    chk({tag, " winner"}, winner, 0);
  endtask

  typedef struct {
    bit tk, st, p1u, p1d, p2u, p2d;
    int e_pad1, e_pad2, e_state;
  } vec_t;
  vec_t vecs[$];

  task automatic add(bit tk, bit st, bit a, bit b, bit c, bit d, int e1, int e2, int es);
    vec_t v;
    v.tk = tk; v.st = st; v.p1u = a; v.p1d = b; v.p2u = c; v.p2d = d;
    v.e_pad1 = e1; v.e_pad2 = e2; v.e_state = es;
    vecs.push_back(v);
  endtask

  initial begin
    int dprev, dmax, dd;
    model_reset();

    // Vector table: idle behaviour, serve entry, paddle clamps.
    add(1, 0, 1, 0, 0, 0, 210, 210, 0);
    add(0, 1, 0, 0, 0, 0, 210, 210, 1);
    add(0, 1, 0, 0, 0, 0, 210, 210, 1);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 0, 0, (180 - 30 * i < 0) ? 0 : 180 - 30 * i, 210, 1);
    for (int i = 0; i < 15; i++) add(0, 0, 0, 1, 0, 0, (30 * (i + 1) > 420) ? 420 : 30 * (i + 1), 210, 1);
    add(0, 0, 1, 1, 0, 0, 420, 210, 1);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 1, 0, 420, (180 - 30 * i < 0) ? 0 : 180 - 30 * i, 1);
    add(0, 0, 0, 0, 1, 1, 420, 0, 1);

    @(negedge CLOCK_25);
    chk_reset("reset");
    RESET_N = 1;

    foreach (vecs[i]) begin
      cyc(vecs[i].tk, vecs[i].st, vecs[i].p1u, vecs[i].p1d, vecs[i].p2u, vecs[i].p2d);
      chk($sformatf("vec%0d pad1_y", i), pad1_y, vecs[i].e_pad1);
      chk($sformatf("vec%0d pad2_y", i), pad2_y, vecs[i].e_pad2);
      chk($sformatf("vec%0d state", i), state, vecs[i].e_state);
    end

    // Serve then centre hit on the left paddle.
    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    ticks(59);
    chk("serve still serving", state, 1);
    ticks(1);
    chk("serve to play", state, 2);
    chk("serve ball held", ball_x, 315);
    ticks(1);
    chk("first move x", ball_x, 311);
    chk("first move y", ball_y, 235);
    ticks(71);
    chk("approach x", ball_x, 27);
    ticks(1);
    chk("centre hit x", ball_x, 25);
    ticks(1);
    chk("centre rebound x", ball_x, 29);
    chk("centre rebound y", ball_y, 235);

    // Zone-0 hit: paddle one step low puts the ball centre on its top row.
    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("zone pad1_y", pad1_y, 240);
    ticks(60 + 73);
    chk("zone hit x", ball_x, 25);
    ticks(1);
    chk("zone0 rebound x", ball_x, 27);
    chk("zone0 rebound y", ball_y, 233);

    // Misses to a full match win for player 2, then restart.
    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    repeat (7) cyc(0, 0, 1, 0, 0, 0);
    chk("miss pad1_y", pad1_y, 0);
    for (int p = 1; p <= 9; p++) begin
      ticks(60 + 79);
      chk($sformatf("miss%0d score2", p), score2, p);
      chk($sformatf("miss%0d state", p), state, (p < 9) ? 1 : 3);
      chk($sformatf("miss%0d ball_x", p), ball_x, 315);
    end
    chk("win winner", winner, 2);
    chk("win score1", score1, 0);
    ticks(3);
    chk("gameover frozen", dpack(), {4'd0, 12'd315, 12'd235, 12'd0, 12'd210, 4'd0, 4'd9, 2'd3, 2'd2});
    cyc(0, 1, 0, 0, 0, 0);
    chk("restart score2", score2, 0);
    chk("restart winner", winner, 0);
    chk("restart state", state, 1);
    chk("restart pad1_y", pad1_y, 210);
    ticks(61);
    chk("serve toward loser", ball_x, 311);

    // Asynchronous reset in the middle of a rally.
    cyc(0, 0, 0, 0, 0, 1);
    #7;
    RESET_N = 0;
    #1;
    chk_reset("async");
    @(negedge CLOCK_25);
    RESET_N = 1;
    model_reset();

`ifdef PONG_SPEEDUP_EN
    // Four centre hits lift the horizontal speed by one.
    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    ticks(60);
    dprev = ball_x;
    dmax = 0;
    repeat (700) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("speedup model", dpack(), mpack());
      dd = int'(ball_x) - dprev;
      if (dd < 0) dd = -dd;
      if (dd > dmax) dmax = dd;
      dprev = ball_x;
    end
    chk("speedup vx", dmax, 5);
`endif

    // Randomised play against the reference model.
    do_reset();
    repeat (8000) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      chk("random vs model", dpack(), mpack());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
